quiz_buzzer_arbiter: RTL and testbench
======================================

Name: quiz_buzzer_arbiter

Overview:
Parametrised N-team quiz buzzer arbiter. It is the generalised successor of the fixed three-group lamp logic.
- Each team has M member buttons with a per-team qualify mode: ANY member, or ALL enabled members.
- First qualifying team lights its lamp and locks out all others; an answer timer then runs.
- Simultaneous qualification is resolved by fixed or round-robin priority.
- Sits between the raw contestant buttons and the lamp/scoreboard logic; host_clr re-arms the round.

Parameters:
N_TEAMS, 3, number of teams (2..16)
MEMBERS, 2, buttons per team (1..8)
TIMER_W, 16, width of the answer timer and limit
RR_PRIO, 1, tie-break policy: 0 = fixed (lowest index wins), 1 = round-robin

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
host_clr  in  1  host clear/re-arm, synchronous, level
btn  in  N_TEAMS*MEMBERS  raw buttons, asynchronous; team t member m at bit t*MEMBERS+m
member_en  in  N_TEAMS*MEMBERS  1 = member present; absent members are ignored
team_all  in  N_TEAMS  1 = all enabled members required (AND), 0 = any enabled member (OR)
answer_limit  in  TIMER_W  answer window in cycles; 0 = no timeout
lamp  out  N_TEAMS  one-hot winner lamp
winner_valid  out  1  a winner is latched
winner_id  out  clog2(N_TEAMS)  index of the latched winner
tie  out  1  one-cycle pulse: more than one team had a new qualification in the winning cycle
timeout  out  1  answer window expired; held until cleared
timer  out  TIMER_W  elapsed cycles in LOCKED

Behaviour:
- Reset: rst_n low at a rising edge gives lamp=0, winner_valid=0, winner_id=0, tie=0, timeout=0, timer=0, state=ARMED, rr_ptr=0, qual_prev=all-ones, sync FFs=0.
- Priority order: rst_n > host_clr > everything else.
- Synchroniser: each btn bit passes through 2 flops (s2 is the stable copy).
- Qualification (combinational on s2):
  - ALL mode: qual[t] = AND over enabled members.
  - ANY mode: qual[t] = OR over enabled members.
  - A team with no enabled members never qualifies.
- New press: new[t] = qual[t] & ~qual_prev[t]; qual_prev is registered every cycle.
- Held buttons: qual_prev is forced to all-ones on reset and on host_clr, so a team held across either must release and re-press before it can win.
- States:
  - ARMED: if any new[t], latch the winner and go to LOCKED.
  - LOCKED: timer increments, saturating at all-ones. If answer_limit!=0 and timer==answer_limit-1, go to TIMEOUT. Presses are ignored.
  - TIMEOUT: lamp=0, winner_valid=0, timeout=1, winner_id holds its value. Presses are ignored.
  - host_clr in any state: go to ARMED; lamp, winner_valid, timeout, timer and tie clear; winner_id and rr_ptr are kept. A press coinciding with host_clr is discarded.
- Latency: btn stable before edge k makes the lamp visible after edge k+2.
- Lamp: equals onehot(winner_id) & winner_valid, registered.
- Timing: LOCKED lasts exactly answer_limit cycles; timeout rises on the cycle after the last LOCKED cycle.
- Tie-break:
  - RR_PRIO=0: lowest new index wins.
  - RR_PRIO=1: first new index >= rr_ptr, searching cyclically.
  - After a win, rr_ptr <= (winner+1) mod N_TEAMS.
- tie pulses for one cycle, coincident with the winner latch, when popcount(new)>1.
- Changes to member_en, team_all or answer_limit take effect immediately (no shadowing). The host changes them only while ARMED.

Decomposition:
- quiz_pkg:
  - state enum {ARMED, LOCKED, TIMEOUT};
  - function for cyclic priority pick from a vector and start pointer;
  - ID width via $clog2.
- Sub-module quiz_team_qualify (one instance per team, generate loop): 2-flop sync of the team's buttons, mask, AND/OR reduce. Outputs qual.
- Top module holds qual_prev, the FSM, the timer and rr_ptr.

Test Plan:
(All scenarios use defaults N_TEAMS=3, MEMBERS=2, member_en=6'b11_01_11, team_all=3'b100, answer_limit=0 unless stated.)
1. Team 0 member 1 pressed at edge k -> lamp=001, winner_valid=1, winner_id=0 after edge k+2. A later team 1 press leaves lamp unchanged.
2. Team 2 presses only member 0 -> lamp stays 0. Team 2 presses both members -> lamp=100, winner_id=2. Team 1 member 1 (disabled) pressed alone -> no win.
3. Teams 1 and 2 qualify in the same cycle, RR_PRIO=1, rr_ptr=0 -> winner_id=1, tie=1 for one cycle. host_clr, release, repeat simultaneous press (rr_ptr=2) -> winner_id=2. Same sequence with RR_PRIO=0 -> team 1 wins both times.
4. Team 0 held across host_clr -> no win while held. Release then re-press -> lamp=001 after 2 edges. Same check for a button held through reset.
5. answer_limit=5, team 1 wins -> timer counts 0..4; next cycle timeout=1, lamp=000, winner_id=1. host_clr -> timeout=0, ARMED.
6. host_clr asserted in the same cycle a new press reaches s2 -> no winner. rst_n low mid-LOCKED -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz buzzer arbiter.
// Team indices are at most 16, so the cyclic pick works on a fixed 16-bit vector.
package quiz_pkg;
  localparam int MAX_TEAMS = 16;
  localparam int PICK_W    = 4;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    LOCKED  = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  // Return the first set index at or after start, wrapping within n entries.
  function automatic logic [PICK_W-1:0] cyclic_pick(input logic [MAX_TEAMS-1:0] vec,
                                                    input logic [PICK_W-1:0]    start,
                                                    input int                   n);
    logic [PICK_W-1:0] pick;
    logic              found;
    int                idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_TEAMS; i++) begin
      idx = int'(start) + i;
      if (idx >= n) idx = idx - n;
      if (!found && i < n && vec[idx[PICK_W-1:0]]) begin
        pick  = idx[PICK_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/quiz_team_qualify.sv
// One team: two-flop synchroniser on each member button, then masked AND/OR
// reduce. A team with no enabled members never qualifies.
module quiz_team_qualify #(
  parameter int MEMBERS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MEMBERS-1:0] btn,
  input  logic [MEMBERS-1:0] en,
  input  logic               all_mode,
  output logic               qual
);
  logic [MEMBERS-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  assign qual = all_mode ? ((|en) && (&(s2 | ~en))) : (|(s2 & en));
endmodule

// File: rtl/quiz_buzzer_arbiter.sv
// N-team quiz buzzer arbiter: first newly-qualifying team wins the lamp and
// locks out the rest until host_clr; optional answer timeout.
module quiz_buzzer_arbiter
  import quiz_pkg::*;
#(
  parameter int N_TEAMS = 3,
  parameter int MEMBERS = 2,
  parameter int TIMER_W = 16,
  parameter int RR_PRIO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_clr,
  input  logic [N_TEAMS*MEMBERS-1:0] btn,
  input  logic [N_TEAMS*MEMBERS-1:0] member_en,
  input  logic [N_TEAMS-1:0]         team_all,
  input  logic [TIMER_W-1:0]         answer_limit,
  output logic [N_TEAMS-1:0]         lamp,
  output logic                       winner_valid,
  output logic [$clog2(N_TEAMS)-1:0] winner_id,
  output logic                       tie,
  output logic                       timeout,
  output logic [TIMER_W-1:0]         timer
);
  localparam int ID_W = $clog2(N_TEAMS);

  logic [N_TEAMS-1:0] qual, qual_prev, new_q;
  logic [PICK_W-1:0]  pick;
  logic [ID_W-1:0]    pick_id, rr_ptr;
  logic [1:0]         warm;
  state_t             state;

  for (genvar g = 0; g < N_TEAMS; g++) begin : g_team
    quiz_team_qualify #(.MEMBERS(MEMBERS)) u_team (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn      (btn[g*MEMBERS +: MEMBERS]),
      .en       (member_en[g*MEMBERS +: MEMBERS]),
      .all_mode (team_all[g]),
      .qual     (qual[g])
    );
  end

  assign new_q   = qual & ~qual_prev;
  assign pick    = cyclic_pick(MAX_TEAMS'(new_q), (RR_PRIO != 0) ? PICK_W'(rr_ptr) : '0, N_TEAMS);
  assign pick_id = ID_W'(pick);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARMED;
      qual_prev    <= '1;
      warm         <= '0;
      rr_ptr       <= '0;
      lamp         <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      tie          <= 1'b0;
      timeout      <= 1'b0;
      timer        <= '0;
    end else begin
      // Sync flops restart at 0 after reset; until they have refilled, treat
      // every team as already held so a button held through reset cannot win.
      warm <= {warm[0], 1'b1};
      tie  <= 1'b0;
      if (host_clr) begin
        state        <= ARMED;
        qual_prev    <= '1;
        lamp         <= '0;
        winner_valid <= 1'b0;
        timeout      <= 1'b0;
        timer        <= '0;
      end else begin
        qual_prev <= warm[1] ? qual : '1;
        case (state)
          ARMED: begin
            if (|new_q) begin
              state        <= LOCKED;
              winner_id    <= pick_id;
              winner_valid <= 1'b1;
              lamp         <= N_TEAMS'(1) << pick_id;
              tie          <= $countones(new_q) > 1;
              rr_ptr       <= (pick_id == ID_W'(N_TEAMS-1)) ? '0 : pick_id + 1'b1;
              timer        <= '0;
            end
          end
          LOCKED: begin
            if (timer != '1) timer <= timer + 1'b1;
            if (answer_limit != '0 && timer == answer_limit - 1'b1) begin
              state        <= TIMEOUT;
              lamp         <= '0;
              winner_valid <= 1'b0;
              timeout      <= 1'b1;
            end
          end
          TIMEOUT: ;
          default: state <= ARMED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_quiz_buzzer_arbiter.sv
// Two arbiters (round-robin and fixed priority) on shared stimulus, checked
// against a counting-level reference model through per-DUT scoreboards.
module tb_quiz_buzzer_arbiter;
  typedef struct {
    bit is_to;
    int id;
    bit tie;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, host_clr = 1'b0;
  logic [5:0]  btn = '0, member_en = 6'b11_01_11;
  logic [2:0]  team_all = 3'b100;
  logic [15:0] answer_limit = '0;

  logic [2:0]  lamp [2];
  logic        wv [2], tie [2], tmo [2];
  logic [1:0]  wid [2];
  logic [15:0] timer [2];

  int   checks = 0, errors = 0;
  bit   mon_on = 1'b0;
  exp_t sbq [2][$];

  // reference model state
  logic [5:0] d1 = '0, d2 = '0;
  int         hist = 0;
  int         ph [2], el [2], ptr [2], mid [2];
  logic [2:0] prev [2];
  logic       pwv [2], pto [2];

  always #5 clk = ~clk;

  quiz_buzzer_arbiter #(.N_TEAMS(3), .MEMBERS(2), .TIMER_W(16), .RR_PRIO(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .host_clr(host_clr), .btn(btn), .member_en(member_en),
    .team_all(team_all), .answer_limit(answer_limit), .lamp(lamp[0]), .winner_valid(wv[0]),
    .winner_id(wid[0]), .tie(tie[0]), .timeout(tmo[0]), .timer(timer[0]));

  quiz_buzzer_arbiter #(.N_TEAMS(3), .MEMBERS(2), .TIMER_W(16), .RR_PRIO(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .host_clr(host_clr), .btn(btn), .member_en(member_en),
    .team_all(team_all), .answer_limit(answer_limit), .lamp(lamp[1]), .winner_valid(wv[1]),
    .winner_id(wid[1]), .tie(tie[1]), .timeout(tmo[1]), .timer(timer[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] qualify(input logic [5:0] b, input logic [5:0] en,
                                         input logic [2:0] all);
    logic [2:0] q;
    int ne, np;
    for (int t = 0; t < 3; t++) begin
      ne = 0;
      np = 0;
      for (int m = 0; m < 2; m++)
        if (en[t*2+m]) begin
          ne++;
          if (b[t*2+m]) np++;
        end
      q[t] = all[t] ? (ne > 0 && np == ne) : (np > 0);
    end
    return q;
  endfunction

  task automatic model_step();
    logic [2:0] q, nw;
    int base, t, cnt;
    exp_t e;
    if (!rst_n) begin
      d1 = '0; d2 = '0; hist = 0;
      for (int d = 0; d < 2; d++) begin
        prev[d] = 3'b111; ph[d] = 0; el[d] = 0; ptr[d] = 0;
      end
    end else begin
      q = qualify(d2, member_en, team_all);
      for (int d = 0; d < 2; d++) begin
        nw = q & ~prev[d];
        if (host_clr) begin
          ph[d] = 0; el[d] = 0;
        end else if (ph[d] == 0 && nw != 0) begin
          cnt  = $countones(nw);
          base = (d == 0) ? ptr[d] : 0;
          t    = -1;
          for (int o = 0; o < 3; o++)
            if (t < 0 && nw[(base+o)%3]) t = (base + o) % 3;
          e.is_to = 1'b0; e.id = t; e.tie = (cnt > 1);
          sbq[d].push_back(e);
          mid[d] = t; ptr[d] = (t + 1) % 3; ph[d] = 1; el[d] = 0;
        end else if (ph[d] == 1) begin
          el[d]++;
          if (answer_limit != 0 && el[d] == int'(answer_limit)) begin
            ph[d] = 2;
            e.is_to = 1'b1; e.id = mid[d]; e.tie = 1'b0;
            sbq[d].push_back(e);
          end
        end
        prev[d] = (host_clr || hist < 2) ? 3'b111 : q;
      end
      if (hist < 2) hist++;
      d2 = d1;
      d1 = btn;
    end
  endtask

  task automatic mon_step();
    exp_t e;
    logic etie;
    logic [2:0] elamp;
    for (int d = 0; d < 2; d++) begin
      etie = 1'b0;
      if ((wv[d] && !pwv[d]) || (tmo[d] && !pto[d])) begin
        if (sbq[d].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event dut%0d: got wv=%0d timeout=%0d id=%0d, required none",
                   d, wv[d], tmo[d], wid[d]);
        end else begin
          e = sbq[d].pop_front();
          chk($sformatf("event_is_timeout dut%0d", d), {31'd0, tmo[d]}, {31'd0, e.is_to});
          chk($sformatf("event_id dut%0d", d), {30'd0, wid[d]}, e.id);
          etie = e.tie;
        end
      end
      chk($sformatf("tie dut%0d", d), {31'd0, tie[d]}, {31'd0, etie});
      chk($sformatf("timer dut%0d", d), {16'd0, timer[d]}, el[d]);
      elamp = wv[d] ? 3'(1 << wid[d]) : 3'b000;
      chk($sformatf("lamp dut%0d", d), {29'd0, lamp[d]}, {29'd0, elamp});
      if (sbq[d].size() != 0) begin
        checks++; errors++;
        $display("FAIL missed_event dut%0d: got no output change, required %0d pending event(s)",
                 d, sbq[d].size());
        sbq[d].delete();
      end
      pwv[d] = wv[d];
      pto[d] = tmo[d];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_on) mon_step();
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    cyc(2);
    if (check) begin
      chk("rst_lamp", {29'd0, lamp[0]}, 0);
      chk("rst_wv", {31'd0, wv[0]}, 0);
      chk("rst_id", {30'd0, wid[0]}, 0);
      chk("rst_tie", {31'd0, tie[0]}, 0);
      chk("rst_timeout", {31'd0, tmo[0]}, 0);
      chk("rst_timer", {16'd0, timer[0]}, 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic clr_pulse();
    host_clr = 1'b1;
    cyc(1);
    host_clr = 1'b0;
  endtask

  initial begin
    pwv = '{1'b0, 1'b0};
    pto = '{1'b0, 1'b0};
    cyc(1);
    do_reset(1'b1);
    mon_on = 1'b1;
    cyc(3);

    // team 0 member 1: two-edge latency, later presses ignored
    btn = 6'b000010;
    cyc(2); chk("s1_lamp_early", {29'd0, lamp[0]}, 0);
    cyc(1); chk("s1_lamp", {29'd0, lamp[0]}, 3'b001);
    chk("s1_id", {30'd0, wid[0]}, 0);
    btn = 6'b000110;
    cyc(4); chk("s1_locked_lamp", {29'd0, lamp[0]}, 3'b001);
    btn = '0; clr_pulse(); cyc(3);

    // team 2 needs both members; disabled member never counts
    btn = 6'b010000;
    cyc(4); chk("s2_partial", {31'd0, wv[0]}, 0);
    btn = 6'b110000;
    cyc(3); chk("s2_lamp", {29'd0, lamp[0]}, 3'b100);
    chk("s2_id", {30'd0, wid[0]}, 2);
    btn = '0; clr_pulse(); cyc(3);
    btn = 6'b001000;
    cyc(4); chk("s2_disabled", {31'd0, wv[0]}, 0);
    btn = '0; cyc(3);

    // simultaneous teams 1 and 2: round-robin vs fixed priority
    do_reset(1'b0); cyc(3);
    btn = 6'b110100;
    cyc(3);
    chk("s3_rr_id1", {30'd0, wid[0]}, 1); chk("s3_rr_tie", {31'd0, tie[0]}, 1);
    chk("s3_fx_id1", {30'd0, wid[1]}, 1); chk("s3_fx_tie", {31'd0, tie[1]}, 1);
    cyc(1); chk("s3_tie_pulse", {31'd0, tie[0]}, 0);
    btn = '0; clr_pulse(); cyc(3);
    btn = 6'b110100;
    cyc(3);
    chk("s3_rr_id2", {30'd0, wid[0]}, 2); chk("s3_fx_id2", {30'd0, wid[1]}, 1);
    btn = '0; clr_pulse(); cyc(3);

    // held across host_clr and across reset
    do_reset(1'b0); cyc(3);
    btn = 6'b000001;
    cyc(3); chk("s4_win", {31'd0, wv[0]}, 1);
    clr_pulse(); cyc(5); chk("s4_held_clr", {31'd0, wv[0]}, 0);
    btn = '0; cyc(3);
    btn = 6'b000001;
    cyc(2); chk("s4_repress_early", {29'd0, lamp[0]}, 0);
    cyc(1); chk("s4_repress", {29'd0, lamp[0]}, 3'b001);
    do_reset(1'b0); cyc(6); chk("s4_held_rst", {31'd0, wv[0]}, 0);
    btn = '0; cyc(3);
    btn = 6'b000001;
    cyc(3); chk("s4_rst_repress", {29'd0, lamp[0]}, 3'b001);
    btn = '0;

    // answer window of 5 cycles
    do_reset(1'b0); answer_limit = 16'd5; cyc(3);
    btn = 6'b000100;
    cyc(3); chk("s5_win", {31'd0, wv[0]}, 1); chk("s5_t0", {16'd0, timer[0]}, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1); chk("s5_timer", {16'd0, timer[0]}, i);
    end
    cyc(1);
    chk("s5_timeout", {31'd0, tmo[0]}, 1); chk("s5_lamp", {29'd0, lamp[0]}, 0);
    chk("s5_id", {30'd0, wid[0]}, 1);
    clr_pulse(); chk("s5_clr_timeout", {31'd0, tmo[0]}, 0);
    btn = '0; answer_limit = '0; cyc(3);

    // press discarded by coincident host_clr; reset in LOCKED
    do_reset(1'b0); cyc(3);
    btn = 6'b000001;
    cyc(2); clr_pulse(); chk("s6_discard", {31'd0, wv[0]}, 0);
    cyc(4); chk("s6_discard_hold", {31'd0, wv[0]}, 0);
    btn = '0; cyc(3);
    btn = 6'b000100;
    cyc(3); chk("s6_win", {31'd0, wv[0]}, 1);
    cyc(2); btn = '0;
    do_reset(1'b1); cyc(3);

    // randomized traffic
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 99) < 30) btn = btn ^ (6'b000001 << $urandom_range(0, 5));
      host_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) answer_limit = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) begin
        member_en = 6'($urandom);
        team_all  = 3'($urandom);
      end
      rst_n = ($urandom_range(0, 149) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    host_clr = 1'b0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
